// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter: register-file geometry,
// parameter defaults, the queued MD result record and the write-slot winner.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int XLEN           = 32;
    localparam int NUM_REGS       = 32;
    localparam int DEPTH_DEF      = 4;
    localparam int STARVE_MAX_DEF = 3;

    typedef struct packed {
        logic                  kill;
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } md_entry_t;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_ALU,
        WIN_FIFO,
        WIN_BYP
    } win_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU and MD result inputs, register-file write port and the
// pending-write mask seen by decode.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_waddr;
    logic [XLEN-1:0]       alu_wdata;
    logic                  alu_stall;
    logic                  md_valid;
    logic                  md_ready;
    logic [REG_ADDR_W-1:0] md_waddr;
    logic [XLEN-1:0]       md_wdata;
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
    logic [NUM_REGS-1:0]   pending_mask;

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata, md_valid, md_waddr, md_wdata,
        output alu_stall, md_ready, we, waddr, wdata, pending_mask
    );

    modport master (
        output alu_valid, alu_waddr, alu_wdata, md_valid, md_waddr, md_wdata,
        input  alu_stall, md_ready, we, waddr, wdata, pending_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of MD results. Entries carry a kill bit that a younger ALU
// write to the same register can set while the entry is still queued.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  md_entry_t             push_entry_i,
    input  logic                  pop_i,
    input  logic                  kill_en_i,
    input  logic [REG_ADDR_W-1:0] kill_addr_i,
    output md_entry_t             head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [NUM_REGS-1:0]   live_mask_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_q, rd_q, count;
    logic [REG_ADDR_W-1:0] addr_q [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];
    logic [DEPTH-1:0]      kill_q, live;
    logic [AW-1:0]         off;

    assign count   = wr_q - rd_q;
    assign empty_o = (count == '0);
    assign full_o  = (count == (AW+1)'(DEPTH));

    assign head_o.kill  = kill_q[rd_q[AW-1:0]];
    assign head_o.waddr = addr_q[rd_q[AW-1:0]];
    assign head_o.wdata = data_q[rd_q[AW-1:0]];

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        off         = '0;
        live        = '0;
        live_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off     = AW'(i) - rd_q[AW-1:0];
            live[i] = ({1'b0, off} < count);
            if (live[i] && !kill_q[i] && addr_q[i] != '0)
                live_mask_o[addr_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            kill_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en_i && live[i] && addr_q[i] == kill_addr_i)
                    kill_q[i] <= 1'b1;
            end
            if (push_i) begin
                kill_q[wr_q[AW-1:0]] <= push_entry_i.kill;
                wr_q                 <= wr_q + 1'b1;
            end
            if (pop_i)
                rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_q[AW-1:0]] <= push_entry_i.waddr;
            data_q[wr_q[AW-1:0]] <= push_entry_i.wdata;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU / queued MD / bypassed MD per cycle for
// the register-file write port, with starvation control and WAW kill of stale MD results.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic                  alu_v, md_v, stall, pop, push, md_rdy, md_hs, kill_en;
    logic                  fifo_empty, fifo_full;
    md_entry_t             head, push_entry;
    logic [NUM_REGS-1:0]   fifo_mask;
    win_e                  win;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  we_q, we_d, out_md_q, out_md_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;

    assign alu_v = bus.alu_valid && !rst;
    assign md_v  = bus.md_valid && !rst;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_en_i    (kill_en),
        .kill_addr_i  (bus.alu_waddr),
        .head_o       (head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .live_mask_o  (fifo_mask)
    );

    // Slot priority: forced drain, ALU, queued MD, then MD bypass into an idle slot.
    always_comb begin
        stall = !rst && !fifo_empty && (starve_q == SW'(STARVE_MAX));
        win   = WIN_NONE;
        if (rst)              win = WIN_NONE;
        else if (stall)       win = WIN_FIFO;
        else if (alu_v)       win = WIN_ALU;
        else if (!fifo_empty) win = WIN_FIFO;
        else if (md_v)        win = WIN_BYP;
        pop              = (win == WIN_FIFO);
        md_rdy           = !rst && (!fifo_full || pop);
        md_hs            = md_v && md_rdy;
        push             = md_hs && (win != WIN_BYP);
        kill_en          = (win == WIN_ALU) && (bus.alu_waddr != '0);
        push_entry.kill  = kill_en && (bus.md_waddr == bus.alu_waddr);
        push_entry.waddr = bus.md_waddr;
        push_entry.wdata = bus.md_wdata;
    end

    always_comb begin
        we_d     = 1'b0;
        out_md_d = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        case (win)
            WIN_ALU: begin
                we_d    = (bus.alu_waddr != '0);
                waddr_d = bus.alu_waddr;
                wdata_d = bus.alu_wdata;
            end
            WIN_FIFO: begin
                we_d     = !head.kill && (head.waddr != '0);
                out_md_d = we_d;
                waddr_d  = head.waddr;
                wdata_d  = head.wdata;
            end
            WIN_BYP: begin
                we_d     = (bus.md_waddr != '0);
                out_md_d = we_d;
                waddr_d  = bus.md_waddr;
                wdata_d  = bus.md_wdata;
            end
            default: ;
        endcase
        if (pop || fifo_empty)  starve_d = '0;
        else if (win == WIN_ALU) starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            out_md_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
        end else begin
            we_q     <= we_d;
            out_md_q <= out_md_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

    assign bus.alu_stall    = stall;
    assign bus.md_ready     = md_rdy;
    assign bus.we           = we_q;
    assign bus.waddr        = waddr_q;
    assign bus.wdata        = wdata_q;
    assign bus.pending_mask = rst ? '0 : (fifo_mask | (out_md_q ? reg_onehot(waddr_q) : '0));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, multi-cycle corner sequences and
// random traffic, all compared cycle by cycle against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;
    localparam int W_NONE = 0, W_ALU = 1, W_FIFO = 2, W_BYP = 3;

    typedef struct {
        bit          r;
        bit          av;
        logic [4:0]  aa;
        logic [31:0] ad;
        bit          mv;
        logic [4:0]  ma;
        logic [31:0] md;
    } in_t;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] mask;
    } obs_t;

    typedef struct {
        in_t  i;
        obs_t e;
    } row_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          kill;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    wb_arbiter_if bus();

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] rf [32];

    // reference model state
    ent_t        mq[$];
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_outmd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_we     = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        m_outmd  = 1'b0;
    endtask

    function automatic in_t mk_in(bit r, bit av, logic [4:0] aa, logic [31:0] ad,
                                  bit mv, logic [4:0] ma, logic [31:0] md);
        in_t x;
        x.r = r; x.av = av; x.aa = aa; x.ad = ad; x.mv = mv; x.ma = ma; x.md = md;
        return x;
    endfunction

    function automatic row_t row(bit r, bit av, logic [4:0] aa, logic [31:0] ad,
                                 bit mv, logic [4:0] ma, logic [31:0] md,
                                 logic st, logic rd, logic we, logic [4:0] wa,
                                 logic [31:0] wd, logic [31:0] mk);
        row_t x;
        x.i = mk_in(r, av, aa, ad, mv, ma, md);
        x.e.stall = st; x.e.ready = rd; x.e.we = we;
        x.e.waddr = wa; x.e.wdata = wd; x.e.mask = mk;
        return x;
    endfunction

    // One clock: drive at negedge, compare against the model, advance both on posedge.
    task automatic step(input in_t in, output obs_t o, output bit alu_acc, output bit md_acc);
        bit          ne, stall, pop, ready, hs;
        int          win;
        logic [31:0] mask;
        ent_t        h;
        rst           = in.r;
        bus.alu_valid = in.av;
        bus.alu_waddr = in.aa;
        bus.alu_wdata = in.ad;
        bus.md_valid  = in.mv;
        bus.md_waddr  = in.ma;
        bus.md_wdata  = in.md;
        #1;
        ne    = (mq.size() != 0);
        stall = !in.r && ne && (m_starve == STARVE_MAX);
        if (in.r)       win = W_NONE;
        else if (stall) win = W_FIFO;
        else if (in.av) win = W_ALU;
        else if (ne)    win = W_FIFO;
        else if (in.mv) win = W_BYP;
        else            win = W_NONE;
        pop   = (win == W_FIFO);
        ready = !in.r && (mq.size() < DEPTH || pop);
        hs    = !in.r && in.mv && ready;
        mask  = '0;
        if (!in.r) begin
            foreach (mq[k]) if (!mq[k].kill && mq[k].addr != 0) mask[mq[k].addr] = 1'b1;
            if (m_outmd) mask[m_waddr] = 1'b1;
        end
        o.stall = bus.alu_stall; o.ready = bus.md_ready; o.we = bus.we;
        o.waddr = bus.waddr; o.wdata = bus.wdata; o.mask = bus.pending_mask;
        check("alu_stall", {31'b0, o.stall}, {31'b0, stall});
        check("md_ready", {31'b0, o.ready}, {31'b0, ready});
        check("we", {31'b0, o.we}, {31'b0, m_we});
        check("waddr", {27'b0, o.waddr}, {27'b0, m_waddr});
        check("wdata", o.wdata, m_wdata);
        check("pending_mask", o.mask, mask);
        if (o.we === 1'b1) rf[o.waddr] = o.wdata;
        alu_acc = (win == W_ALU);
        md_acc  = hs;
        @(posedge clk);
        if (in.r) begin
            model_reset();
        end else begin
            case (win)
                W_ALU: begin
                    m_we = (in.aa != 0); m_waddr = in.aa; m_wdata = in.ad; m_outmd = 1'b0;
                    if (in.aa != 0) foreach (mq[k]) if (mq[k].addr == in.aa) mq[k].kill = 1'b1;
                end
                W_FIFO: begin
                    h = mq.pop_front();
                    m_we = !h.kill && (h.addr != 0); m_waddr = h.addr; m_wdata = h.data;
                    m_outmd = m_we;
                end
                W_BYP: begin
                    m_we = (in.ma != 0); m_waddr = in.ma; m_wdata = in.md; m_outmd = m_we;
                end
                default: begin
                    m_we = 1'b0; m_outmd = 1'b0;
                end
            endcase
            if (pop || !ne)        m_starve = 0;
            else if (win == W_ALU) m_starve = m_starve + 1;
            if (hs && win != W_BYP) begin
                h.addr = in.ma; h.data = in.md;
                h.kill = (win == W_ALU) && (in.aa != 0) && (in.ma == in.aa);
                mq.push_back(h);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        row_t tbl[14];
        obs_t o;
        bit   aacc, macc;
        in_t  in;
        int   ai, mi, cnt;

        foreach (rf[k]) rf[k] = '0;
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_waddr = '0; bus.alu_wdata = '0;
        bus.md_valid  = 1'b0; bus.md_waddr  = '0; bus.md_wdata  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        //             r av aa  ad         mv ma md          st rd we wa wd          mask
        tbl[0]  = row(1, 0, 0,  0,         0, 0, 0,          0, 0, 0, 0, 0,          0);
        tbl[1]  = row(0, 1, 5,  32'h1234,  0, 0, 0,          0, 1, 0, 0, 0,          0);
        tbl[2]  = row(0, 0, 0,  0,         0, 0, 0,          0, 1, 1, 5, 32'h1234,   0);
        tbl[3]  = row(0, 0, 0,  0,         0, 0, 0,          0, 1, 0, 5, 32'h1234,   0);
        tbl[4]  = row(0, 0, 0,  0,         1, 7, 32'hDEAD,   0, 1, 0, 5, 32'h1234,   0);
        tbl[5]  = row(0, 0, 0,  0,         0, 0, 0,          0, 1, 1, 7, 32'hDEAD,   32'h80);
        tbl[6]  = row(0, 0, 0,  0,         0, 0, 0,          0, 1, 0, 7, 32'hDEAD,   0);
        tbl[7]  = row(0, 1, 1,  32'h11,    1, 9, 32'hAAAA,   0, 1, 0, 7, 32'hDEAD,   0);
        tbl[8]  = row(0, 1, 9,  32'hBBBB,  0, 0, 0,          0, 1, 1, 1, 32'h11,     32'h200);
        tbl[9]  = row(0, 0, 0,  0,         0, 0, 0,          0, 1, 1, 9, 32'hBBBB,   0);
        tbl[10] = row(0, 0, 0,  0,         0, 0, 0,          0, 1, 0, 9, 32'hAAAA,   0);
        tbl[11] = row(0, 1, 0,  32'h77,    0, 0, 0,          0, 1, 0, 9, 32'hAAAA,   0);
        tbl[12] = row(0, 0, 0,  0,         1, 0, 32'h88,     0, 1, 0, 0, 32'h77,     0);
        tbl[13] = row(0, 0, 0,  0,         0, 0, 0,          0, 1, 0, 0, 32'h88,     0);

        for (int k = 0; k < 14; k++) begin
            step(tbl[k].i, o, aacc, macc);
            check($sformatf("row%0d.stall", k), {31'b0, o.stall}, {31'b0, tbl[k].e.stall});
            check($sformatf("row%0d.ready", k), {31'b0, o.ready}, {31'b0, tbl[k].e.ready});
            check($sformatf("row%0d.we", k), {31'b0, o.we}, {31'b0, tbl[k].e.we});
            check($sformatf("row%0d.waddr", k), {27'b0, o.waddr}, {27'b0, tbl[k].e.waddr});
            check($sformatf("row%0d.wdata", k), o.wdata, tbl[k].e.wdata);
            check($sformatf("row%0d.mask", k), o.mask, tbl[k].e.mask);
        end
        check("r9_final", rf[9], 32'hBBBB);

        // Starvation: ALU busy every cycle with two MD results behind it.
        ai = 0; mi = 0; cnt = 0;
        for (int c = 0; c < 14; c++) begin
            in = mk_in(0, 0, 0, 0, 0, 0, 0);
            if (ai < 8) begin in.av = 1; in.aa = 5'(10 + ai); in.ad = 32'hA000 + 32'(ai); end
            if (mi < 2) begin in.mv = 1; in.ma = 5'(3 + mi); in.md = 32'hC000 + 32'(mi); end
            step(in, o, aacc, macc);
            if (aacc) ai++;
            if (macc) mi++;
            if (o.stall === 1'b1) cnt++;
        end
        check("starve_stall_cycles", 32'(cnt), 32'd2);
        check("starve_r3", rf[3], 32'hC000);
        check("starve_r4", rf[4], 32'hC001);
        for (int k = 0; k < 8; k++)
            check($sformatf("starve_alu_r%0d", 10 + k), rf[10 + k], 32'hA000 + 32'(k));

        // Fill the FIFO behind a busy ALU; full-with-pop still accepts.
        step(mk_in(1, 0, 0, 0, 0, 0, 0), o, aacc, macc);
        ai = 0; mi = 0;
        for (int c = 0; c < 20; c++) begin
            in = mk_in(0, 0, 0, 0, 0, 0, 0);
            if (ai < 10) begin in.av = 1; in.aa = 5'(10 + (ai % 8)); in.ad = 32'hB000 + 32'(ai); end
            if (mi < 6) begin in.mv = 1; in.ma = 5'(20 + mi); in.md = 32'hD000 + 32'(mi); end
            step(in, o, aacc, macc);
            if (c == 4) check("fill_ready_pop_full", {31'b0, o.ready}, 32'd1);
            if (c == 5) check("fill_ready_full", {31'b0, o.ready}, 32'd0);
            if (aacc) ai++;
            if (macc) mi++;
        end
        for (int k = 0; k < 6; k++)
            check($sformatf("fill_r%0d", 20 + k), rf[20 + k], 32'hD000 + 32'(k));

        // Reset with three MD results queued: nothing of them may be written.
        step(mk_in(1, 0, 0, 0, 0, 0, 0), o, aacc, macc);
        for (int c = 0; c < 3; c++)
            step(mk_in(0, 1, 5'(11 + c), 32'hE000, 1, 5'(26 + c), 32'hF000 + 32'(c)), o, aacc, macc);
        step(mk_in(1, 1, 5'd12, 32'hE111, 1, 5'd29, 32'hF111), o, aacc, macc);
        check("rst_md_ready", {31'b0, o.ready}, 32'd0);
        check("rst_alu_stall", {31'b0, o.stall}, 32'd0);
        check("rst_mask", o.mask, 32'd0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step(mk_in(0, 0, 0, 0, 0, 0, 0), o, aacc, macc);
            if (o.we !== 1'b0) cnt++;
        end
        check("rst_no_writes", 32'(cnt), 32'd0);
        for (int k = 0; k < 3; k++)
            check($sformatf("rst_r%0d_untouched", 26 + k), rf[26 + k], 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            in.r  = ($urandom_range(0, 99) == 0);
            in.av = ($urandom_range(0, 3) != 0);
            in.aa = 5'($urandom_range(0, 7));
            in.ad = $urandom;
            in.mv = ($urandom_range(0, 9) < 6);
            in.ma = 5'($urandom_range(0, 7));
            in.md = $urandom;
            step(in, o, aacc, macc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 32x32 register file. Drives its write port (we/waddr/wdata), one write per cycle.
- Merges two result sources: the single-cycle ALU and a multi-cycle mul/div unit (MD). MD results wait in a small FIFO while the ALU holds the write slot.
- Publishes a pending-write mask that decode uses for hazard stalls.

Parameters:
- DEPTH, 4, MD result FIFO entries; power of two, minimum 2.
- STARVE_MAX, 3, consecutive ALU-won slots tolerated while the FIFO is non-empty before the ALU is stalled.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_waddr  in  5  ALU destination register.
- alu_wdata  in  32  ALU result.
- alu_stall  out  1  ALU result not accepted this cycle; upstream holds it.
- md_valid  in  1  MD result offered.
- md_ready  out  1  MD result accepted when md_valid && md_ready.
- md_waddr  in  5  MD destination register.
- md_wdata  in  32  MD result.
- we  out  1  register-file write enable, registered.
- waddr  out  5  register-file write address, registered.
- wdata  out  32  register-file write data, registered.
- pending_mask  out  32  bit i = live MD write to r[i] queued or in the output register.

Behaviour:
- Reset (rst high at posedge): we=0, waddr=0, wdata=0, FIFO empty with all kill bits clear, starve counter=0. While rst is high: md_ready=0, alu_stall=0, pending_mask=0.
- Output register: we/waddr/wdata load at each posedge from the slot winner. Latency is exactly 1 cycle from acceptance (or FIFO head) to output. With no winner: we=0, waddr and wdata hold their previous values.
- Slot winner, evaluated each cycle in this order:
  1. alu_stall=1 and FIFO non-empty: FIFO head wins; the ALU result is not accepted.
  2. alu_valid=1: ALU wins.
  3. FIFO non-empty: head wins and pops.
  4. FIFO empty and an MD handshake occurs: the MD result bypasses the FIFO straight into the output register.
  5. Otherwise no write.
- An MD handshake that does not win the slot enqueues. Enqueue and pop in the same cycle are legal, including when the FIFO is full (pop frees the slot). md_ready = !rst && (count<DEPTH || pop this cycle).
- Writes to address 0 are consumed normally but drive we=0. Such entries never set a pending_mask bit.
- Starvation control:
  - Counter increments on each ALU-won cycle with the FIFO non-empty.
  - Counter clears when a FIFO entry pops, or when the FIFO is empty.
  - alu_stall = (counter==STARVE_MAX) && FIFO non-empty; this is combinational.
- Ordering: queued MD results are older than any concurrent ALU write.
  - An ALU write to rX (X≠0) sets the kill bit on every FIFO entry with waddr==X.
  - An MD result accepted in that same cycle with waddr==X is also killed.
  - A killed entry still drains in FIFO order but emits we=0.
- pending_mask is the OR over valid, non-killed FIFO entries plus the output register when it holds an MD write. It is registered, reflecting state after the last edge.
- Count wraps are handled by DEPTH-sized pointers with an extra wrap bit. Full is count==DEPTH; empty is count==0.
- Reset mid-operation clears all queued results without emitting any write. md_valid and alu_valid are ignored while rst is high.

Decomposition:
- Shared package constants: REG_ADDR_W=5, XLEN=32, NUM_REGS=32. Parameter defaults are also defined there.
- One sub-module: wb_fifo. It is a DEPTH-entry synchronous FIFO of {kill, waddr, wdata} with a per-entry kill port (kill_en, kill_addr) and a vector of live entry addresses for pending_mask.

Test Plan:
- Reset, then alu_valid=1, alu_waddr=5, alu_wdata=0x1234 for 1 cycle -> next cycle we=1, waddr=5, wdata=0x1234; following cycle we=0.
- MD only: md_valid with waddr=7, data=0xDEAD, FIFO empty -> md_ready=1, we=1/waddr=7 next cycle, pending_mask[7]=1 for exactly that cycle.
- ALU valid every cycle plus 2 MD results (r3, r4) -> after 3 ALU writes alu_stall=1 for one cycle and r3 drains; the pattern repeats for r4; no write is lost.
- Fill FIFO with 4 MD results while the ALU is busy -> md_ready=0 on the 5th; pop and enqueue in the same cycle keeps count=4.
- Queue MD r9=0xAAAA, then an ALU write r9=0xBBBB -> the r9 entry later drains with we=0; r9 ends at 0xBBBB; pending_mask[9] clears the cycle after the ALU write.
- Write to r0 from either source -> we=0, pending_mask=0; assert rst with 3 entries queued -> we=0 thereafter, FIFO empty, md_ready=0 during reset.
